tl_sensor_latch: RTL and testbench
==================================

# tl_sensor_latch

Vehicle-detector front end for the traffic-light controller. Synchronises and debounces four raw loop-detector inputs, latches a per-approach demand, and drives the 4-bit `sensor` vector consumed by the light state machine. It watches the per-approach light signals coming back from the controller, and clears each demand once that approach has been served. A stuck-detector watchdog forces permanent demand on a faulty approach and flags it.

## Interface
- `DEB_CYCLES`, default 16'd3: number of consecutive differing samples before the debounced detector state flips; must be ≥ 1.
- `STUCK_CYCLES`, default 16'd6000: continuous debounced-presence cycles after which an approach is declared faulty; must be ≥ 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `arst` input 1: asynchronous, active-high reset.
- `det_raw` input [3:0]: raw detector levels, asynchronous to `clk`; bit i is approach i.
- `tl_sig_arr` input [2:0] ×4: light signal per approach; 3'b100 red, 3'b010 yellow, 3'b001 green, 3'b000 dark.
- `sensor` output [3:0]: registered demand per approach, driven to the controller.
- `fault` output [3:0]: sticky stuck-detector flag per approach.

## Operation
- Everything below is done independently for each approach i (0..3).
- Synchroniser: two flops, `det_raw[i]` → s1 → s.
- Debounce:
  - State is deb (1 bit) plus a 16-bit counter dc.
  - If s == deb: dc ← 0.
  - Else if dc == DEB_CYCLES-1: deb ← s and dc ← 0.
  - Else: dc ← dc+1.
  - Debounce is symmetric, so rising and falling edges are both filtered.
- Service detection:
  - g_q ← (`tl_sig_arr[i]` == 3'b001).
  - serve_end = g_q & (`tl_sig_arr[i]` != 3'b001), i.e. green → any other value, including dark.
- Demand register: req ← fault_i | deb | (req & ~serve_end).
  - Set has priority over clear.
  - A vehicle still present at the end of green keeps the demand set.
  - `sensor[i]` = req.
- Watchdog:
  - 16-bit counter wc.
  - wc ← 0 when deb == 0.
  - wc ← wc+1 when deb == 1, saturating at STUCK_CYCLES.
  - When wc reaches STUCK_CYCLES, fault_i ← 1.
  - fault_i is sticky until `arst`. A faulty approach keeps `sensor[i]` = 1 regardless of detector or service.

## Timing
- Reset: while `arst` = 1, the following are all 0: s1, s, deb, dc, g_q, req, wc, fault. Therefore `sensor` = 4'b0000 and `fault` = 4'b0000. Release takes effect at the first rising edge after deassertion.
- Reset mid-operation drops all pending demands and faults immediately (asynchronously); no state is retained.
- Assertion latency (edge E0 is the first edge that samples `det_raw[i]` = 1, and the input is held stable):
  - s = 1 after E1.
  - deb = 1 after E(1+DEB_CYCLES).
  - `sensor[i]` = 1 after E(2+DEB_CYCLES), i.e. on the DEB_CYCLES+3-th edge.
- A raw pulse shorter than DEB_CYCLES samples at s never changes deb or `sensor`.
- Deassertion has the same DEB_CYCLES+2 latency to deb. `sensor` then stays 1 until serve_end.
- Clear: `sensor[i]` falls at the edge after the first cycle in which `tl_sig_arr[i]` leaves green, provided deb = 0 and fault = 0 at that edge.
- Simultaneous deb rise and serve_end: demand stays set.
- Fault latency: fault_i rises at the STUCK_CYCLES-th consecutive edge with deb = 1 (counted from the edge after deb rose).
- Counter widths are 16 bits. wc saturates and never wraps. dc never exceeds DEB_CYCLES-1.

## Test plan
- Reset: assert `arst` with `det_raw` = 4'b1111 → `sensor` = 4'b0000 and `fault` = 4'b0000 throughout reset, at every clock and asynchronously at assertion.
- Debounce (DEB_CYCLES = 3):
  - `det_raw[0]` high for 2 clocks then low → `sensor` stays 4'b0000.
  - `det_raw[0]` held high → `sensor[0]` = 1 after the 6th edge, and not before.
- Service clear: `det_raw[2]` pulse latched into `sensor[2]` = 1, then `det_raw[2]` low; `tl_sig_arr[2]` goes 100 → 001 (5 clocks) → 010 → `sensor[2]` falls one edge after yellow is applied. Other bits are unaffected.
- Present at end of green: as above, but `det_raw[2]` held high through the green → yellow transition → `sensor[2]` remains 1.
- Dark clear: green → 3'b000 on approach 1 with `det_raw[1]` low → `sensor[1]` clears one edge later.
- Watchdog (STUCK_CYCLES = 20): `det_raw[3]` held high.
  - → `fault[3]` = 1 exactly 20 edges after deb rose.
  - Then `det_raw[3]` low plus a full green → yellow service → `sensor[3]` stays 1 and `fault[3]` stays 1 until `arst`.

Source files
------------

// File: rtl/tl_sensor_latch.sv
// tl_sensor_latch
// Vehicle-detector front end for the traffic-light controller. Each of the
// four approaches has its own two-flop synchroniser, symmetric debouncer,
// demand latch cleared on the end of green, and stuck-detector watchdog.
// A faulty approach holds its demand permanently until reset.
module tl_sensor_latch #(
  parameter logic [15:0] DEB_CYCLES   = 16'd3,
  parameter logic [15:0] STUCK_CYCLES = 16'd6000
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [3:0]      det_raw,
  input  logic [3:0][2:0] tl_sig_arr,
  output logic [3:0]      sensor,
  output logic [3:0]      fault
);

  localparam logic [2:0]  SIG_GREEN = 3'b001;
  // Last count value before the debounced state is allowed to flip.
  localparam logic [15:0] DEB_LAST  = DEB_CYCLES - 16'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_approach
      logic        s1_reg;
      logic        s_reg;
      logic        deb_reg;
      logic        deb_next;
      logic [15:0] dc_reg;
      logic [15:0] dc_next;
      logic        g_q_reg;
      logic        green_now;
      logic        serve_end;
      logic        req_reg;
      logic        req_next;
      logic [15:0] wc_reg;
      logic [15:0] wc_next;
      logic        fault_reg;
      logic        fault_next;

      assign green_now = (tl_sig_arr[gi] == SIG_GREEN);
      // Green was showing last cycle and is not showing now (any other
      // value, including dark, counts as the end of service).
      assign serve_end = g_q_reg & ~green_now;

      // Debounce: the synchronised level must disagree with the debounced
      // state for DEB_CYCLES consecutive samples before the state flips.
      always_comb begin
        deb_next = deb_reg;
        dc_next  = dc_reg;
        if (s_reg == deb_reg) begin
          dc_next = '0;
        end else if (dc_reg == DEB_LAST) begin
          deb_next = s_reg;
          dc_next  = '0;
        end else begin
          dc_next = dc_reg + 16'd1;
        end
      end

      // Watchdog: count continuous debounced presence, saturate, and latch
      // the fault on the edge where the count reaches the limit.
      always_comb begin
        wc_next = wc_reg;
        if (!deb_reg) begin
          wc_next = '0;
        end else if (wc_reg < STUCK_CYCLES) begin
          wc_next = wc_reg + 16'd1;
        end
        fault_next = fault_reg | (deb_reg & (wc_next == STUCK_CYCLES));
      end

      // Demand latch: set (fault or presence) wins over the service clear,
      // so a vehicle still waiting at the end of green keeps its demand.
      always_comb begin
        req_next = fault_reg | deb_reg | (req_reg & ~serve_end);
      end

      // State registers for this approach, all cleared asynchronously.
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          s1_reg    <= 1'b0;
          s_reg     <= 1'b0;
          deb_reg   <= 1'b0;
          dc_reg    <= '0;
          g_q_reg   <= 1'b0;
          req_reg   <= 1'b0;
          wc_reg    <= '0;
          fault_reg <= 1'b0;
        end else begin
          s1_reg    <= det_raw[gi];
          s_reg     <= s1_reg;
          deb_reg   <= deb_next;
          dc_reg    <= dc_next;
          g_q_reg   <= green_now;
          req_reg   <= req_next;
          wc_reg    <= wc_next;
          fault_reg <= fault_next;
        end
      end

      assign sensor[gi] = req_reg;
      assign fault[gi]  = fault_reg;
    end
  endgenerate

endmodule

// File: tb/tb_tl_sensor_latch.sv
// Testbench for tl_sensor_latch: directed scenarios followed by a random
// phase, all cross-checked against a cycle-level behavioural model that
// tracks sample runs and presence durations per approach.
module tb_tl_sensor_latch;

  localparam int DEB   = 3;
  localparam int STUCK = 20;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  logic            clk;
  logic            arst;
  logic [3:0]      det_raw;
  logic [3:0][2:0] tl_sig_arr;
  logic [3:0]      sensor;
  logic [3:0]      fault;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0]      raw_v;
  logic [3:0][2:0] sig_v;
  logic [2:0]      sig_tbl [4];

  // Behavioural model state, one entry per approach.
  bit m_s1 [4];
  bit m_s  [4];
  bit m_deb [4];
  int m_run [4];     // consecutive samples disagreeing with m_deb
  bit m_g  [4];
  bit m_req [4];
  int m_pres [4];    // debounced-presence cycles, saturating at STUCK
  bit m_fault [4];

  tl_sensor_latch #(
    .DEB_CYCLES  (16'(DEB)),
    .STUCK_CYCLES(16'(STUCK))
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .det_raw   (det_raw),
    .tl_sig_arr(tl_sig_arr),
    .sensor    (sensor),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 0; m_s[i] = 0; m_deb[i] = 0; m_run[i] = 0;
      m_g[i] = 0; m_req[i] = 0; m_pres[i] = 0; m_fault[i] = 0;
    end
  endtask

  // One rising edge of the model, using the inputs applied before the edge.
  task automatic model_step(input logic [3:0] raw, input logic [3:0][2:0] sig);
    bit served, n_req, n_deb, n_fault;
    int n_run, n_pres;
    for (int i = 0; i < 4; i++) begin
      served = m_g[i] && (sig[i] != GREEN);
      n_req  = m_fault[i] || m_deb[i] || (m_req[i] && !served);
      n_pres = m_deb[i] ? ((m_pres[i] + 1 > STUCK) ? STUCK : m_pres[i] + 1) : 0;
      n_fault = m_fault[i] || (m_deb[i] && n_pres >= STUCK);
      n_deb = m_deb[i];
      if (m_s[i] == m_deb[i]) n_run = 0;
      else if (m_run[i] + 1 >= DEB) begin n_deb = m_s[i]; n_run = 0; end
      else n_run = m_run[i] + 1;
      m_req[i] = n_req; m_pres[i] = n_pres; m_fault[i] = n_fault;
      m_deb[i] = n_deb; m_run[i] = n_run;
      m_s[i] = m_s1[i]; m_s1[i] = raw[i]; m_g[i] = (sig[i] == GREEN);
    end
  endtask

  function automatic logic [3:0] m_sensor_v();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_req[i];
    return v;
  endfunction

  function automatic logic [3:0] m_fault_v();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_fault[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Apply inputs, take one edge, advance the model, compare 1 ns later.
  task automatic tick(input logic [3:0] raw, input logic [3:0][2:0] sig);
    det_raw    = raw;
    tl_sig_arr = sig;
    @(posedge clk);
    model_step(raw, sig);
    #1;
    check("model_sensor", sensor, m_sensor_v());
    check("model_fault", fault, m_fault_v());
  endtask

  initial begin
    sig_tbl = '{RED, YELLOW, GREEN, DARK};
    arst = 1'b1;
    det_raw = 4'hF;
    tl_sig_arr = {4{RED}};
    model_reset();

    // Reset held with all detectors active.
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_sensor", sensor, 4'b0000);
      check("reset_fault", fault, 4'b0000);
    end
    arst = 1'b0;
    raw_v = 4'b0000;
    sig_v = {4{RED}};
    repeat (3) tick(raw_v, sig_v);
    check("idle_sensor", sensor, 4'b0000);

    // Short pulse on approach 0 never reaches the output.
    raw_v[0] = 1'b1;
    repeat (2) tick(raw_v, sig_v);
    raw_v[0] = 1'b0;
    repeat (6) begin
      tick(raw_v, sig_v);
      check("short_pulse", sensor, 4'b0000);
    end

    // Held input: sensor[0] rises on the 6th edge, not before.
    raw_v[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(raw_v, sig_v);
      check_bit("assert_latency", sensor[0], k >= 6);
    end
    raw_v[0] = 1'b0;
    repeat (8) tick(raw_v, sig_v);
    check_bit("latched_no_service", sensor[0], 1'b1);

    // Service clear on approach 2.
    raw_v[2] = 1'b1;
    repeat (5) tick(raw_v, sig_v);
    raw_v[2] = 1'b0;
    repeat (8) tick(raw_v, sig_v);
    check_bit("svc_latched", sensor[2], 1'b1);
    sig_v[2] = GREEN;
    repeat (5) begin
      tick(raw_v, sig_v);
      check_bit("svc_green_hold", sensor[2], 1'b1);
    end
    sig_v[2] = YELLOW;
    tick(raw_v, sig_v);
    check_bit("svc_clear", sensor[2], 1'b0);
    check("svc_others", sensor, 4'b0001);
    sig_v[2] = RED;
    tick(raw_v, sig_v);

    // Vehicle still present at end of green keeps the demand.
    raw_v[2] = 1'b1;
    repeat (6) tick(raw_v, sig_v);
    check_bit("present_latched", sensor[2], 1'b1);
    sig_v[2] = GREEN;
    repeat (5) tick(raw_v, sig_v);
    sig_v[2] = YELLOW;
    tick(raw_v, sig_v);
    check_bit("present_keep", sensor[2], 1'b1);
    sig_v[2] = RED;
    raw_v[2] = 1'b0;
    repeat (8) tick(raw_v, sig_v);
    check_bit("present_after", sensor[2], 1'b1);

    // Green to dark also counts as service on approach 1.
    raw_v[1] = 1'b1;
    repeat (5) tick(raw_v, sig_v);
    raw_v[1] = 1'b0;
    repeat (8) tick(raw_v, sig_v);
    check_bit("dark_latched", sensor[1], 1'b1);
    sig_v[1] = GREEN;
    repeat (3) tick(raw_v, sig_v);
    sig_v[1] = DARK;
    tick(raw_v, sig_v);
    check_bit("dark_clear", sensor[1], 1'b0);
    sig_v[1] = RED;
    tick(raw_v, sig_v);

    // Watchdog on approach 3: deb rises on the 5th edge, fault 20 edges later.
    raw_v[3] = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick(raw_v, sig_v);
      check_bit("wd_latency", fault[3], k >= 25);
    end
    raw_v[3] = 1'b0;
    repeat (8) tick(raw_v, sig_v);
    sig_v[3] = GREEN;
    repeat (5) tick(raw_v, sig_v);
    sig_v[3] = YELLOW;
    tick(raw_v, sig_v);
    check_bit("wd_sensor_held", sensor[3], 1'b1);
    check_bit("wd_fault_sticky", fault[3], 1'b1);
    sig_v[3] = RED;
    repeat (4) tick(raw_v, sig_v);
    check("wd_fault_vec", fault, 4'b1000);

    // Random phase against the model.
    repeat (400) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3) == 0) raw_v[i] = ~raw_v[i];
        if ($urandom_range(7) == 0) sig_v[i] = sig_tbl[$urandom_range(3)];
      end
      tick(raw_v, sig_v);
    end

    // Asynchronous reset mid-operation clears everything immediately.
    check_bit("pre_reset_nonzero", sensor[3], 1'b1);
    #2;
    arst = 1'b1;
    #1;
    check("async_reset_sensor", sensor, 4'b0000);
    check("async_reset_fault", fault, 4'b0000);
    raw_v = 4'hF;
    det_raw = raw_v;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      check("reset2_sensor", sensor, 4'b0000);
      check("reset2_fault", fault, 4'b0000);
    end
    arst = 1'b0;
    raw_v = 4'b0000;
    sig_v = {4{RED}};
    repeat (10) begin
      tick(raw_v, sig_v);
      check("post_reset_idle", sensor, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
